// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
// Turns the raw, asynchronous, bouncy street-A/street-B vehicle detectors into
// clean traffic-present levels TA/TB for the traffic-light controller, plus a
// one-cycle arrival pulse per debounced car. Each channel is a 2-flop
// synchronizer, a debounce filter and an IDLE/OCCUPIED/HOLD occupancy FSM.
// Optional feature: define TRAFFIC_COUNT_EN to add saturating arrival counters
// (count_a/count_b) with a clear_counts input; without it those ports do not exist.
module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
`ifdef TRAFFIC_COUNT_EN
    ,
    parameter int CNT_W           = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sensor_a_raw,
    input  logic             sensor_b_raw,
`ifdef TRAFFIC_COUNT_EN
    input  logic             clear_counts,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
`endif
    output logic             TA,
    output logic             TB,
    output logic             car_a_pulse,
    output logic             car_b_pulse
);

    // Counter widths hold DEBOUNCE_CYCLES-1 and HOLD_CYCLES-1; at least one bit.
    localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OCCUPIED = 2'd1,
        HOLD     = 2'd2
    } hold_state_t;

    logic [1:0] raw;
    logic [1:0] present;
    logic [1:0] pulse;

    assign raw = {sensor_b_raw, sensor_a_raw};

    // Channel 0 is street A, channel 1 is street B; the two never interact.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic              s1;
        logic              s2;
        logic              filt;
        logic [DCNT_W-1:0] dcnt;
        logic [HCNT_W-1:0] hcnt;
        logic [HCNT_W-1:0] hcnt_next;
        hold_state_t       state;
        hold_state_t       state_next;
        logic              pulse_r;

        // Bring the asynchronous detector into the clock domain.
        always_ff @(posedge clock) begin
            if (reset) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= raw[ch];
                s2 <= s1;
            end
        end

        // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge clock) begin
            if (reset) begin
                filt <= 1'b0;
                dcnt <= '0;
            end else if (s2 == filt) begin
                dcnt <= '0;
            end else if (dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DCNT_W'(1);
            end
        end

        // Occupancy next-state: a re-arrival during HOLD wins over hold expiry.
        always_comb begin
            state_next = state;
            hcnt_next  = hcnt;
            case (state)
                IDLE: begin
                    if (filt) state_next = OCCUPIED;
                end
                OCCUPIED: begin
                    if (!filt) begin
                        state_next = HOLD;
                        hcnt_next  = HCNT_W'(HOLD_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (filt) begin
                        state_next = OCCUPIED;
                    end else if (hcnt == '0) begin
                        state_next = IDLE;
                    end else begin
                        hcnt_next = hcnt - HCNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // State register; the arrival pulse marks every entry into OCCUPIED.
        always_ff @(posedge clock) begin
            if (reset) begin
                state   <= IDLE;
                hcnt    <= '0;
                pulse_r <= 1'b0;
            end else begin
                state   <= state_next;
                hcnt    <= hcnt_next;
                pulse_r <= (state_next == OCCUPIED) && (state != OCCUPIED);
            end
        end

        assign present[ch] = (state != IDLE);
        assign pulse[ch]   = pulse_r;
    end

    assign TA          = present[0];
    assign TB          = present[1];
    assign car_a_pulse = pulse[0];
    assign car_b_pulse = pulse[1];

`ifdef TRAFFIC_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating arrival counters; clear beats a coincident arrival.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            count_a <= '0;
            count_b <= '0;
        end else begin
            if (car_a_pulse && (count_a != CNT_MAX)) count_a <= count_a + CNT_W'(1);
            if (car_b_pulse && (count_b != CNT_MAX)) count_b <= count_b + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
- Upstream stage of the two-street traffic-light controller.
- Converts raw, asynchronous, bouncy vehicle-detector inputs for street A and street B into the clean traffic-present levels TA/TB that the controller consumes.
- Per channel: 2-flop synchronizer, debounce filter, occupancy-hold FSM. Also emits one-cycle car-arrival pulses.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before the filtered level changes (must be >= 1).
- HOLD_CYCLES, 8: cycles TA/TB stay high after the filtered sensor falls (must be >= 1).
- CNT_W, 8: width of the car counters (optional feature only).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sensor_a_raw  in  1  asynchronous street-A detector.
- sensor_b_raw  in  1  asynchronous street-B detector.
- TA  out  1  street-A traffic present, registered.
- TB  out  1  street-B traffic present, registered.
- car_a_pulse  out  1  one-cycle pulse per filtered rising edge on A.
- car_b_pulse  out  1  one-cycle pulse per filtered rising edge on B.
- clear_counts  in  1  clear both counters (TRAFFIC_COUNT_EN only).
- count_a  out  CNT_W  A arrivals, saturating (TRAFFIC_COUNT_EN only).
- count_b  out  CNT_W  B arrivals, saturating (TRAFFIC_COUNT_EN only).

Behaviour:
- Reset (synchronous, active-high, on clock):
  - All outputs 0.
  - Sync flops, filtered levels, debounce/hold counters and counters 0.
  - FSMs in IDLE.
  - Reset mid-operation drops TA/TB at the next edge. A raw input still held high afterwards needs the full rise latency again.
- Channels A and B are identical and fully independent; no cross-coupling.
- Synchronizer: raw -> s1 -> s2, one flop each edge.
- Debounce:
  - Counter dcnt counts while s2 != filt.
  - When dcnt == DEBOUNCE_CYCLES-1 and s2 still differs: filt <= s2, dcnt <= 0.
  - Any cycle with s2 == filt clears dcnt.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach filt.
- Hold FSM, states IDLE / OCCUPIED / HOLD:
  - IDLE: filt rise -> OCCUPIED.
  - OCCUPIED: filt fall -> HOLD, hcnt <= HOLD_CYCLES-1.
  - HOLD: filt rise -> OCCUPIED (priority over expiry); else hcnt == 0 -> IDLE; else hcnt decrements.
  - TA/TB = (state != IDLE), registered state decode.
- Latency (edge 1 = first edge sampling the raw change, raw stable after):
  - TA rises after edge DEBOUNCE_CYCLES+3.
  - TA falls after edge DEBOUNCE_CYCLES+HOLD_CYCLES+3.
  - Defaults: rise at edge 7, fall at edge 15.
- car_x_pulse:
  - High exactly one cycle on each filt rising edge, including a re-entry HOLD -> OCCUPIED.
  - Aligned with the cycle the FSM enters OCCUPIED.
  - A and B may pulse in the same cycle.
- Continuous raw high produces one pulse only. TA stays high indefinitely.

Optional Feature:
- Macro: TRAFFIC_COUNT_EN.
- When defined:
  - count_a/count_b increment on car_a_pulse/car_b_pulse (the counter update lands the edge after the pulse cycle).
  - Saturate at 2^CNT_W-1; no wrap.
  - clear_counts zeroes both on the next edge and has priority over a simultaneous increment.
  - Reset zeroes both.
- When undefined: clear_counts, count_a and count_b ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, then sensor_a_raw held high from edge 1: TA=0 through edge 6, TA=1 after edge 7; car_a_pulse high for exactly that one cycle; TB=0 throughout.
- sensor_a_raw glitch high for 3 cycles (DEBOUNCE_CYCLES=4): TA stays 0 and car_a_pulse never asserts.
- A high long enough to assert, then low from edge 1: TA stays 1 through edge 14 and drops after edge 15.
- A falls, then rises again while in HOLD (4 cycles after entering HOLD, debounced): TA never drops; second car_a_pulse issued; count_a = 2 (with TRAFFIC_COUNT_EN).
- A and B raw rise on the same edge: TA and TB rise together after edge 7; both pulses in the same cycle; then reset asserted while both occupied -> TA=TB=0 and counts 0 after the next edge.
- TRAFFIC_COUNT_EN, CNT_W=2: 5 separate debounced A arrivals -> count_a saturates at 3; clear_counts asserted in the same cycle as a pulse -> count_a=0.
